// File: rtl/iq_demod.sv
// Lock-in I/Q demodulator: mixes the ADC stream with a cos/sin LO and
// integrates each product over 2^DEC_LOG2-sample frames (accumulate-and-dump).
module iq_demod #(
  parameter int IN_WIDTH  = 14,
  parameter int LUT_WIDTH = 16,
  parameter int DEC_LOG2  = 8,
  parameter int OUT_WIDTH = 25
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic signed [IN_WIDTH-1:0]  sample_in,
  input  logic        [31:0]          freq,
  input  logic        [31:0]          phase_offset,
  input  logic                        sync,
  output logic signed [OUT_WIDTH-1:0] i_out,
  output logic signed [OUT_WIDTH-1:0] q_out,
  output logic                        out_valid
);

  localparam int  PROD_W    = IN_WIDTH + LUT_WIDTH;
  localparam int  ACC_W     = PROD_W + DEC_LOG2;
  localparam int  SHIFT     = ACC_W - OUT_WIDTH;
  localparam int  LUT_DEPTH = 1024;
  localparam real TWO_PI    = 6.283185307179586;
  localparam logic [DEC_LOG2-1:0] CNT_LAST = '1;

  // One full sine period, round(32767*sin(2*pi*k/1024)). The table is
  // computed at elaboration rather than read from an external init file so
  // the block carries its own contents.
  function automatic logic signed [LUT_WIDTH-1:0] lut_entry(input int k);
    real v;
    int  r;
    v = 32767.0 * $sin(TWO_PI * real'(k) / real'(LUT_DEPTH));
    if (v >= 0.0) r = $rtoi(v + 0.5);
    else          r = -$rtoi(0.5 - v);
    return LUT_WIDTH'(r);
  endfunction

  logic signed [LUT_WIDTH-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    assign lut_rom[k] = lut_entry(k);
  end

  logic        [31:0]          phase_acc;
  logic        [9:0]           addr_sin;
  logic        [9:0]           addr_cos;
  logic signed [LUT_WIDTH-1:0] sin_q;
  logic signed [LUT_WIDTH-1:0] cos_q;
  logic signed [IN_WIDTH-1:0]  x_d;
  logic signed [PROD_W-1:0]    mul_i;
  logic signed [PROD_W-1:0]    mul_q;
  logic signed [PROD_W-1:0]    prod_i;
  logic signed [PROD_W-1:0]    prod_q;
  logic        [1:0]           vld;
  logic signed [ACC_W-1:0]     acc_i;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     sum_i;
  logic signed [ACC_W-1:0]     sum_q;
  logic signed [OUT_WIDTH-1:0] dump_i;
  logic signed [OUT_WIDTH-1:0] dump_q;
  logic        [DEC_LOG2-1:0]  cnt;

  // LO phase accumulator, restarted at phase zero by reset or sync
  always_ff @(posedge sys_clk) begin
    if (sys_rst || sync) phase_acc <= '0;
    else                 phase_acc <= phase_acc + freq;
  end

  // Top 10 bits of the offset phase address the table; cos leads sin by a quarter period
  assign addr_sin = 10'((phase_acc + phase_offset) >> 22);
  assign addr_cos = addr_sin + 10'd256;

  // Registered table read, with the sample delayed one stage to stay aligned
  always_ff @(posedge sys_clk) begin
    sin_q <= lut_rom[addr_sin];
    cos_q <= lut_rom[addr_cos];
    x_d   <= sample_in;
  end

  assign mul_i = PROD_W'(x_d) * PROD_W'(cos_q);
  assign mul_q = PROD_W'(x_d) * PROD_W'(sin_q);

  // Full-precision product register
  always_ff @(posedge sys_clk) begin
    prod_i <= mul_i;
    prod_q <= mul_q;
  end

  // Valid tags for the LUT/sample stage (bit 0) and the product stage (bit 1)
  always_ff @(posedge sys_clk) begin
    if (sys_rst || sync) vld <= '0;
    else                 vld <= {vld[0], 1'b1};
  end

  assign sum_i  = acc_i + ACC_W'(prod_i);
  assign sum_q  = acc_q + ACC_W'(prod_q);
  assign dump_i = OUT_WIDTH'(sum_i >>> SHIFT);
  assign dump_q = OUT_WIDTH'(sum_q >>> SHIFT);

  // Accumulate-and-dump: the last product of a frame goes straight to the output
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
    end else if (sync) begin
      // outputs keep their last frame result across a restart
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (vld[1]) begin
        if (cnt == CNT_LAST) begin
          i_out     <= dump_i;
          q_out     <= dump_q;
          out_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + DEC_LOG2'(1);
        end
      end
    end
  end

endmodule
